// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the scoreboarded register file: sequencer states and
// default geometry.
package regfile_scoreboard_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int DEFAULT_WIDTH         = 16;
  localparam int DEFAULT_REGISTER_BITS = 4;
  localparam int DEPTH                 = 1 << DEFAULT_REGISTER_BITS;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero-register override, write bypass, then
// stored data qualified by the busy scoreboard.
module regfile_read_port #(
  parameter int WIDTH         = 16,
  parameter int REGISTER_BITS = 4,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                     running,
  input  logic [REGISTER_BITS-1:0] address,
  input  logic                     shouldWrite,
  input  logic [REGISTER_BITS-1:0] writeAddress,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [WIDTH-1:0]         storedData,
  input  logic                     storedBusy,
  output logic [WIDTH-1:0]         data,
  output logic                     ready
);

  always_comb begin
    data  = '0;
    ready = 1'b0;
    if (running) begin
      if (ZERO_REG != 0 && address == '0) begin
        ready = 1'b1;
      end else if (BYPASS != 0 && shouldWrite && writeAddress == address) begin
        data  = writeData;
        ready = 1'b1;
      end else begin
        data  = storedData;
        ready = !storedBusy;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with busy scoreboard for hazard detection and a
// post-reset sequencer that zeroes every register before accepting traffic.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int REGISTER_BITS = DEFAULT_REGISTER_BITS,
  parameter int READ_PORTS    = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                shouldWrite,
  input  logic [REGISTER_BITS-1:0]            writeAddress,
  input  logic [WIDTH-1:0]                    writeData,
  input  logic [READ_PORTS*REGISTER_BITS-1:0] readAddress,
  output logic [READ_PORTS*WIDTH-1:0]         readData,
  output logic [READ_PORTS-1:0]               readReady,
  input  logic                                reserveValid,
  input  logic [REGISTER_BITS-1:0]            reserveAddress,
  output logic                                reserveAccept,
  output logic                                initDone
);

  localparam int REG_COUNT = 1 << REGISTER_BITS;

  logic [WIDTH-1:0]       DataBlock [REG_COUNT];
  logic [REG_COUNT-1:0]   busy;
  logic [REGISTER_BITS:0] clearCount, clearCountNext;
  rf_state_t              state, stateNext;
  logic                   running, writeEn, writeStores, reserveSetsBusy;

  always_comb begin
    running         = (state == RUN) && !reset;
    writeEn         = running && shouldWrite;
    writeStores     = writeEn && !(ZERO_REG != 0 && writeAddress == '0);
    reserveAccept   = running && reserveValid &&
                      (!busy[reserveAddress] || (writeEn && writeAddress == reserveAddress));
    reserveSetsBusy = reserveAccept && !(ZERO_REG != 0 && reserveAddress == '0);
    initDone        = running;
    clearCountNext  = clearCount + (REGISTER_BITS + 1)'(1);
    stateNext       = state;
    // Carry into the extra bit marks the edge that clears the last index.
    if (state == CLEAR && clearCountNext[REGISTER_BITS]) stateNext = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clearCount <= '0;
      busy       <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) clearCount <= clearCountNext;
      // Set after clear so a same-cycle accepted reserve leaves the register busy.
      if (writeStores)     busy[writeAddress]   <= 1'b0;
      if (reserveSetsBusy) busy[reserveAddress] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state == CLEAR) begin
      DataBlock[clearCount[REGISTER_BITS-1:0]] <= '0;
    end else if (writeStores) begin
      DataBlock[writeAddress] <= writeData;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [REGISTER_BITS-1:0] addr;
    assign addr = readAddress[p*REGISTER_BITS +: REGISTER_BITS];

    regfile_read_port #(
      .WIDTH         (WIDTH),
      .REGISTER_BITS (REGISTER_BITS),
      .ZERO_REG      (ZERO_REG),
      .BYPASS        (BYPASS)
    ) u_port (
      .running      (running),
      .address      (addr),
      .shouldWrite  (writeEn),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .storedData   (DataBlock[addr]),
      .storedBusy   (busy[addr]),
      .data         (readData[p*WIDTH +: WIDTH]),
      .ready        (readReady[p])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two instances (zero-reg+bypass, plain) share stimulus and
// are checked against a behavioural model of the register file rules.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        shouldWrite = 1'b0;
  logic [3:0]  writeAddress = '0;
  logic [15:0] writeData = '0;
  logic [7:0]  readAddress = '0;
  logic        reserveValid = 1'b0;
  logic [3:0]  reserveAddress = '0;

  logic [31:0] rdA, rdB;
  logic [1:0]  rrA, rrB;
  logic        accA, accB, doneA, doneB;

  always #5 clock = ~clock;

  regfile_scoreboard #(.WIDTH(16), .REGISTER_BITS(4), .READ_PORTS(2), .ZERO_REG(1), .BYPASS(1)) dutA (
    .clock(clock), .reset(reset), .shouldWrite(shouldWrite), .writeAddress(writeAddress),
    .writeData(writeData), .readAddress(readAddress), .readData(rdA), .readReady(rrA),
    .reserveValid(reserveValid), .reserveAddress(reserveAddress), .reserveAccept(accA),
    .initDone(doneA));

  regfile_scoreboard #(.WIDTH(16), .REGISTER_BITS(4), .READ_PORTS(2), .ZERO_REG(0), .BYPASS(0)) dutB (
    .clock(clock), .reset(reset), .shouldWrite(shouldWrite), .writeAddress(writeAddress),
    .writeData(writeData), .readAddress(readAddress), .readData(rdB), .readReady(rrB),
    .reserveValid(reserveValid), .reserveAddress(reserveAddress), .reserveAccept(accB),
    .initDone(doneB));

  typedef struct packed {
    logic [31:0]      cyc;
    logic [3:0][15:0] data;   // index d*2+p
    logic [3:0]       ready;
    logic [1:0]       accept;
    logic [1:0]       done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference state: per-instance register contents and pending-write flags,
  // plus the number of clear cycles completed since reset.
  logic [15:0] mMem  [2][DEPTH];
  bit          mBusy [2][DEPTH];
  int          clearsDone = 0;
  bit          zr [2] = '{1'b1, 1'b0};
  bit          bp [2] = '{1'b1, 1'b0};

  task automatic step(input logic rst, input logic sw, input logic [3:0] wa, input logic [15:0] wd,
                      input logic rv, input logic [3:0] ra, input logic [3:0] a0, input logic [3:0] a1);
    exp_t e;
    bit   run;
    @(posedge clock);
    #1;
    reset = rst; shouldWrite = sw; writeAddress = wa; writeData = wd;
    reserveValid = rv; reserveAddress = ra; readAddress = {a1, a0};
    cycle++;
    run   = !rst && clearsDone >= DEPTH;
    e     = '0;
    e.cyc = cycle;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        logic [3:0] a;
        a = (p == 0) ? a0 : a1;
        if (!run) begin
          e.data[d*2+p] = 16'h0; e.ready[d*2+p] = 1'b0;
        end else if (zr[d] && a == 0) begin
          e.data[d*2+p] = 16'h0; e.ready[d*2+p] = 1'b1;
        end else if (bp[d] && sw && wa == a) begin
          e.data[d*2+p] = wd; e.ready[d*2+p] = 1'b1;
        end else begin
          e.data[d*2+p] = mMem[d][a]; e.ready[d*2+p] = !mBusy[d][a];
        end
      end
      e.accept[d] = run && rv && (!mBusy[d][ra] || (sw && wa == ra));
      e.done[d]   = run;
    end
    q.push_back(e);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mBusy[d][i] = 1'b0;
      end else if (clearsDone < DEPTH) begin
        mMem[d][clearsDone] = 16'h0;
      end else begin
        if (sw && !(zr[d] && wa == 0)) begin
          mMem[d][wa] = wd; mBusy[d][wa] = 1'b0;
        end
        if (e.accept[d] && !(zr[d] && ra == 0)) mBusy[d][ra] = 1'b1;
      end
    end
    if (rst) clearsDone = 0;
    else if (clearsDone < DEPTH) clearsDone++;
  endtask

  task automatic idle(input int n, input logic [3:0] a0, input logic [3:0] a1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, a0, a1);
  endtask

  task automatic cmp(input string name, input int d, input int cyc, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %h expected %h", name, d, cyc, got, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < 2; p++) begin
          cmp($sformatf("readData%0d", p), 0, e.cyc, rdA[p*16 +: 16], e.data[p]);
          cmp($sformatf("readData%0d", p), 1, e.cyc, rdB[p*16 +: 16], e.data[2+p]);
          cmp($sformatf("readReady%0d", p), 0, e.cyc, {15'b0, rrA[p]}, {15'b0, e.ready[p]});
          cmp($sformatf("readReady%0d", p), 1, e.cyc, {15'b0, rrB[p]}, {15'b0, e.ready[2+p]});
        end
        cmp("reserveAccept", 0, e.cyc, {15'b0, accA}, {15'b0, e.accept[0]});
        cmp("reserveAccept", 1, e.cyc, {15'b0, accB}, {15'b0, e.accept[1]});
        cmp("initDone", 0, e.cyc, {15'b0, doneA}, {15'b0, e.done[0]});
        cmp("initDone", 1, e.cyc, {15'b0, doneB}, {15'b0, e.done[1]});
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) begin
        mMem[d][i] = 16'h0; mBusy[d][i] = 1'b0;
      end

    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd5, 4'd5);
    // Clear phase with a write to r4 that must be ignored.
    idle(2, 4'd5, 4'd4);
    step(1'b0, 1'b1, 4'd4, 16'h5555, 1'b1, 4'd4, 4'd5, 4'd4);
    idle(14, 4'd5, 4'd4);
    for (int i = 0; i < DEPTH; i++) idle(1, 4'(i), 4'(15 - i));

    // Issue then writeback with bypass.
    step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd3, 4'd3, 4'd3);
    idle(1, 4'd3, 4'd3);
    step(1'b0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd3, 4'd3);
    idle(1, 4'd3, 4'd3);

    // WAW stall and write/reserve collision.
    step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd7, 4'd7, 4'd7);
    step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd7, 4'd7, 4'd7);
    step(1'b0, 1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 4'd7, 4'd7);
    idle(1, 4'd7, 4'd7);
    step(1'b0, 1'b1, 4'd7, 16'h2222, 1'b0, 4'd0, 4'd7, 4'd7);

    // Zero register.
    step(1'b0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(1, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd0, 4'd0, 4'd0);
    idle(1, 4'd0, 4'd0);

    // Reset while r2 is busy holding 0xAAAA.
    step(1'b0, 1'b1, 4'd2, 16'hAAAA, 1'b0, 4'd0, 4'd2, 4'd2);
    step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 4'd2, 4'd2, 4'd2);
    step(1'b1, 1'b0, 4'd0, 16'h0,    1'b0, 4'd0, 4'd2, 4'd2);
    idle(17, 4'd2, 4'd2);

    // Reset landing at clear index 9.
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd1);
    idle(9, 4'd9, 4'd1);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd9, 4'd1);
    idle(18, 4'd9, 4'd1);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 399) == 0), 1'($urandom), 4'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
           4'($urandom_range(0, 7)));
    end
    idle(1, 4'd0, 4'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
